// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and bit-reflection helper for the CRC stream engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package crc_pkg;

    // CRC-32/ISO-HDLC (Ethernet FCS)
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // CRC-16/CCITT, reflected variant (KERMIT)
    localparam logic [31:0] CRC16_POLY    = 32'h00001021;
    localparam logic [31:0] CRC16_INIT    = 32'h00000000;
    localparam logic [31:0] CRC16_XOROUT  = 32'h00000000;
    localparam logic [31:0] CRC16_RESIDUE = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } crc_state_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] reflect_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte folded into a CRC_W-bit register, bit-serial unrolled.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int          CRC_W   = 32,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter bit          REFLECT = 1'b1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    // Reflected mode runs the register LSB-first, so it shifts right with the mirrored polynomial.
    localparam logic [31:0]      POLY_R32 = reflect_bits(POLY, CRC_W);
    localparam logic [CRC_W-1:0] POLY_N   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] POLY_R   = POLY_R32[CRC_W-1:0];

    // Eight shift/xor steps for one byte
    always_comb begin
        logic [CRC_W-1:0] c;
        c = crc_in;
        if (REFLECT) begin
            c[7:0] = c[7:0] ^ data;
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
            end
        end else begin
            c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ data;
            for (int b = 0; b < 8; b++) begin
                c = c[CRC_W-1] ? ((c << 1) ^ POLY_N) : (c << 1);
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker, DATA_W/8 byte lanes per beat; optional residue check via CRC_STREAM_CHECK_EN.
// Latency: result valid the cycle after the last beat is accepted.
// Backpressure: s_ready drops while a result waits in HOLD; result held until crc_ready.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int          CRC_W   = 32,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOROUT  = CRC32_XOROUT,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [CRC_W-1:0]    crc_value
`ifdef CRC_STREAM_CHECK_EN
    ,
    output logic                crc_ok
`endif
);

    localparam int LANES = DATA_W / 8;

    // The register lives in the shift domain, so a non-symmetric INIT must be mirrored too.
    localparam logic [31:0]      INIT_R32 = REFLECT ? reflect_bits(INIT, CRC_W) : INIT;
    localparam logic [CRC_W-1:0] INIT_V   = INIT_R32[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_V    = XOROUT[CRC_W-1:0];

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] chain    [LANES+1];
    logic [CRC_W-1:0] step_out [LANES];
    logic             accept;
    logic             release_hold;

    assign s_ready      = (state_q != ST_HOLD);
    assign crc_valid    = (state_q == ST_HOLD);
    assign accept       = s_valid & s_ready;
    assign release_hold = (state_q == ST_HOLD) & crc_ready;

    // Lane chain: keep only masks lanes on the last beat; contiguous keep means a skipped lane ends the data.
    assign chain[0] = crc_reg;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        crc_byte_step #(
            .CRC_W   (CRC_W),
            .POLY    (POLY),
            .REFLECT (REFLECT)
        ) u_step (
            .crc_in  (chain[i]),
            .data    (s_data[8*i +: 8]),
            .crc_out (step_out[i])
        );
        assign chain[i+1] = (s_last && !s_keep[i]) ? chain[i] : step_out[i];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: frames run until an accepted last beat, then hold until the result is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN: if (accept) state_d = s_last ? ST_HOLD : ST_RUN;
            ST_HOLD:         if (crc_ready) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Running CRC register; reloads INIT as the result is handed off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            crc_reg <= INIT_V;
        else if (release_hold) crc_reg <= INIT_V;
        else if (accept)       crc_reg <= chain[LANES];
    end

    // Result register, captured on the edge accepting the last beat and frozen through HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 crc_value <= '0;
        else if (accept && s_last)  crc_value <= chain[LANES] ^ XOR_V;
    end

`ifdef CRC_STREAM_CHECK_EN
    localparam logic [CRC_W-1:0] RES_V = RESIDUE[CRC_W-1:0];

    // Residue comparator, registered alongside crc_value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 crc_ok <= 1'b0;
        else if (accept && s_last)  crc_ok <= (chain[LANES] == RES_V);
    end
`else
    logic unused_residue;
    assign unused_residue = ^RESIDUE;
`endif

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised streaming CRC generator/checker, successor to the team's fixed 8-bit CRC-32 byte engine. Accepts a valid/ready byte stream of configurable width (1, 2 or 4 byte lanes per beat) with frame delimiting and a partial last beat. Produces one registered CRC per frame on a separate valid/ready result channel. Sits between the TTC frame buffers and the uplink/downlink framers, for both FCS generation and FCS checking.

## Interface
- DATA_W, 8: beat width in bits; 8, 16 or 32.
- CRC_W, 32: CRC width; 16 or 32.
- POLY, 32'h04C11DB7: generator polynomial, normal form, low CRC_W bits used.
- INIT, 32'hFFFFFFFF: register preset at frame start.
- XOROUT, 32'hFFFFFFFF: XOR applied to the result.
- REFLECT, 1: 1 = LSB-first bits and reflected output; 0 = MSB-first, no reflection.
- RESIDUE, 32'hDEBB20E3: raw register value for a good frame that includes its FCS.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine accepts a beat.
- s_data  in  DATA_W  beat data; byte lane 0 is processed first.
- s_keep  in  DATA_W/8  lane enables; honoured on the last beat only.
- s_last  in  1  final beat of the frame.
- crc_valid  out  1  result valid.
- crc_ready  in  1  result consumed.
- crc_value  out  CRC_W  final CRC, `(register ^ XOROUT)`.
- crc_ok  out  1  raw register == RESIDUE (CRC_STREAM_CHECK_EN only).

## Operation
- A beat is accepted on `s_valid & s_ready`. Lanes are processed in order 0..N-1 within the cycle.
- Non-last beats: s_keep is ignored and all lanes are used.
- Last beat: s_keep must be contiguous from lane 0; lanes with keep=0 are skipped. Non-contiguous keep is undefined; the bench must not drive it.
- keep=0 on the last beat closes the frame without adding bytes.
- FSM states:
  - IDLE: register = INIT. Accepting a beat without s_last → RUN. Accepting a beat with s_last → HOLD.
  - RUN: accepting a beat without s_last → RUN; accepting a beat with s_last → HOLD.
  - HOLD: crc_valid=1; crc_value and crc_ok are held. On `crc_valid & crc_ready` → IDLE, and the register reloads INIT in the same edge.
- `s_ready = (state != HOLD)`.
- Upper bits of POLY, INIT, XOROUT and RESIDUE above CRC_W are ignored.

## Timing
- Reset values: crc_valid=0, crc_value=0, crc_ok=0, state IDLE, register=INIT, s_ready=1.
- Latency: crc_valid rises on the edge that accepts the last beat, i.e. it is visible the cycle after that beat.
- Throughput: one beat per cycle inside a frame. Minimum one bubble between frames (the HOLD cycle), even with crc_ready tied high.
- crc_value is stable while `crc_valid & !crc_ready`.
- rst_n low mid-frame or in HOLD: the partial frame and any pending result are discarded, with no crc_valid pulse.
- Combinational path: DATA_W/8 chained byte steps, register to register, no path from input to output.

## Configuration
- CRC_STREAM_CHECK_EN defined: the crc_ok port and the RESIDUE comparator exist. crc_ok is registered with crc_value.
- CRC_STREAM_CHECK_EN undefined: the crc_ok port and comparator are removed; RESIDUE is unused. All other behaviour is identical.

## Structure
- Package crc_pkg holds:
  - default polynomial, init, xorout and residue constants for CRC-32/ISO-HDLC and CRC-16/CCITT;
  - the FSM state typedef (IDLE/RUN/HOLD);
  - a reflect-bits function.
- Sub-module crc_byte_step: combinational, one byte into a CRC_W register, parametrised by POLY, CRC_W and REFLECT. The top instantiates it DATA_W/8 times in a chain, with a keep-mux after each lane.
- The top holds the FSM, register, output registers and comparator.

## Test plan
- DATA_W=8, "123456789" (0x31..0x39), s_last on 0x39 → crc_value=0xCBF43926, crc_valid one cycle after the last beat.
- DATA_W=32, same 9 bytes in 3 beats, last beat keep=4'b0001 → crc_value=0xCBF43926; repeat back-to-back with crc_ready=1 → one bubble, identical second result.
- CHECK_EN, DATA_W=16, "123456789"+0x26,0x39,0xF4,0xCB, last beat keep=2'b01 → crc_ok=1. Flip data bit 0 of byte 0 → crc_ok=0.
- Single beat, s_last=1, keep=0 → crc_value=0x00000000 (INIT^XOROUT).
- crc_ready low for 5 cycles in HOLD → s_ready=0, crc_value stable, no beats accepted. crc_ready high → IDLE next cycle, s_ready=1.
- rst_n pulsed low after 4 bytes of a frame → crc_valid stays 0. Then "123456789" → 0xCBF43926.
